alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
Instruction buffer and issue stage directly upstream of the ALU input interface. It accepts instructions from the decode stage over a valid/ready handshake and holds them in a FIFO of DEPTH entries. It drives ACT/OP/MOVI/REG_A/REG_B/IMM/MEM into the ALU only when ALU_RDY is high. It also counts in-flight operations against EX_ALU_VLD returns so that the number of unretired ALU operations is bounded.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the shared ALU parameter package
DEPTH, 4, FIFO entries; power of two, at least 2
MAX_OUTSTANDING, 2, maximum issued-but-not-returned ALU operations; at least 1

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-low reset (RST=0 resets immediately; RST=1 runs)
IN_VLD  in  1  decode offers an instruction
IN_RDY  out  1  queue can accept; a push occurs on IN_VLD && IN_RDY
IN_OP  in  4  ALU operation
IN_MOVI  in  2  second-operand select
IN_REG_A  in  DATA_WIDTH  operand A
IN_REG_B  in  DATA_WIDTH  operand B
IN_IMM  in  DATA_WIDTH  immediate
IN_MEM  in  DATA_WIDTH  memory operand
ACT  out  1  issue strobe to ALU
ALU_RDY  in  1  ALU ready to accept an instruction
OP  out  4  to ALU
MOVI  out  2  to ALU
REG_A  out  DATA_WIDTH  to ALU
REG_B  out  DATA_WIDTH  to ALU
IMM  out  DATA_WIDTH  to ALU
MEM  out  DATA_WIDTH  to ALU
EX_ALU_VLD  in  1  ALU result valid; retires one operation
COUNT  out  $clog2(DEPTH)+1  FIFO occupancy
OUTSTANDING  out  $clog2(MAX_OUTSTANDING)+1  in-flight count
RESULT_ERR  out  1  sticky flag: result returned with nothing in flight

Behaviour:
- Reset (RST=0, asynchronous): FIFO empty, rd/wr pointers 0, COUNT=0, OUTSTANDING=0, RESULT_ERR=0, ACT=0.
- Payload outputs (OP..MEM) show the FIFO head combinationally (fall-through). They are don't-care when empty but must not be X after reset: storage is reset to 0.
- IN_RDY = (COUNT != DEPTH). It is purely a function of registered state.
- When full, a push is refused even if a pop happens in the same cycle; no combinational path from ALU_RDY to IN_RDY.
- ACT = (COUNT != 0) && ALU_RDY && (OUTSTANDING != MAX_OUTSTANDING). This is combinational from ALU_RDY and registered state.
- A pop occurs whenever ACT=1; the ALU samples the head on that same edge.
- Payload is stable while ACT=0.
- Push writes at wr_ptr. Pointers wrap modulo DEPTH. Simultaneous push and pop leaves COUNT unchanged.
- Push into an empty queue: the entry is issuable in the next cycle, so minimum latency is 1 cycle from IN_VLD&&IN_RDY to ACT.
- OUTSTANDING:
  - +1 on ACT, -1 on EX_ALU_VLD; both in the same cycle leave it unchanged.
  - EX_ALU_VLD with OUTSTANDING=0 and ACT=0: counter stays 0 and RESULT_ERR is set. RESULT_ERR clears only on reset.
  - EX_ALU_VLD with OUTSTANDING=0 and ACT=1: legal (zero-latency ALU op); counter stays 0.
- MULT (OP=2): no special-casing; the ALU's own ALU_RDY deassertion stalls issue.
- Ordering is strict FIFO: no reordering, no drops, no duplicates.
- Reset asserted mid-operation discards all queued and in-flight state. Results arriving after reset release with OUTSTANDING=0 raise RESULT_ERR.

Decomposition:
- Shared package (sv_alu_param_pkg): DATA_WIDTH, the op encoding constants (MULT=4'd2, etc.), and a packed struct alu_instr_t {op[3:0], movi[1:0], reg_a, reg_b, imm, mem}.
- One natural sub-module, alu_instr_fifo: a generic fall-through FIFO of alu_instr_t with push/pop/count/full/empty and async active-low reset.
- alu_issue_queue adds the issue gating, the outstanding counter and RESULT_ERR.

Test Plan:
- Reset then idle, ALU_RDY=1 → ACT=0, IN_RDY=1, COUNT=0, OUTSTANDING=0, RESULT_ERR=0.
- Push ADD (OP=0, REG_A=8'h05, REG_B=8'h03) at cycle 0, ALU_RDY=1 → ACT=1 at cycle 1 with OP=0, REG_A=05, REG_B=03; OUTSTANDING=1 after; EX_ALU_VLD two cycles later returns it to 0.
- Push 4 instructions with ALU_RDY=0 → COUNT=4, IN_RDY=0. A fifth IN_VLD is held and not accepted. Raise ALU_RDY and pulse EX_ALU_VLD each cycle → ACT each cycle, issued in push order, then the fifth is accepted.
- MAX_OUTSTANDING=2, ALU_RDY=1, 3 queued, no EX_ALU_VLD → exactly 2 ACT pulses, then ACT=0 with COUNT=1 and OUTSTANDING=2. One EX_ALU_VLD → third ACT next cycle.
- Issue MULT (OP=2) followed by ADD, with the ALU model dropping ALU_RDY for 9 cycles after the MULT → ADD ACT occurs exactly when ALU_RDY returns, not before.
- EX_ALU_VLD pulse with OUTSTANDING=0 → RESULT_ERR=1 and it stays set. Assert RST=0 mid-burst with COUNT=3 → COUNT, OUTSTANDING, RESULT_ERR and ACT go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sv_alu_param_pkg.sv
// Shared ALU parameters: operand width, op encodings and the instruction
// payload carried from decode through the issue queue into the ALU.
package sv_alu_param_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned OP_WIDTH   = 4;
  localparam int unsigned MOVI_WIDTH = 2;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_MULT = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd5;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [MOVI_WIDTH-1:0] movi;
    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] mem;
  } alu_instr_t;

endpackage

// File: rtl/alu_instr_fifo.sv
// Fall-through FIFO of ALU instructions. The head entry is visible on
// head_c whenever the FIFO is non-empty. A push while full is refused even
// if a pop happens in the same cycle; a pop while empty is ignored.
// Ports: clk, rst_n (async active-low), push/wdata, pop, head_c,
//        count (occupancy), full, empty.
module alu_instr_fifo
  import sv_alu_param_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  alu_instr_t             wdata,
  input  logic                   pop,
  output alu_instr_t             head_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  alu_instr_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem_q[rd_ptr];

  // Storage is reset so the fall-through head never shows X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= wdata;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Instruction buffer and issue stage in front of the ALU. Buffers decode
// instructions in a fall-through FIFO, issues the head (ACT) when the ALU is
// ready and the in-flight budget allows, and tracks issued-but-unreturned
// operations against EX_ALU_VLD.
// Ports: CLK, RST (async active-low); decode side IN_VLD/IN_RDY + IN_* payload;
//        ALU side ACT, ALU_RDY, OP/MOVI/REG_A/REG_B/IMM/MEM, EX_ALU_VLD;
//        status COUNT, OUTSTANDING, RESULT_ERR (sticky).
module alu_issue_queue
  import sv_alu_param_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             IN_VLD,
  output logic                             IN_RDY,
  input  logic [OP_WIDTH-1:0]              IN_OP,
  input  logic [MOVI_WIDTH-1:0]            IN_MOVI,
  input  logic [DATA_WIDTH-1:0]            IN_REG_A,
  input  logic [DATA_WIDTH-1:0]            IN_REG_B,
  input  logic [DATA_WIDTH-1:0]            IN_IMM,
  input  logic [DATA_WIDTH-1:0]            IN_MEM,
  output logic                             ACT,
  input  logic                             ALU_RDY,
  output logic [OP_WIDTH-1:0]              OP,
  output logic [MOVI_WIDTH-1:0]            MOVI,
  output logic [DATA_WIDTH-1:0]            REG_A,
  output logic [DATA_WIDTH-1:0]            REG_B,
  output logic [DATA_WIDTH-1:0]            IMM,
  output logic [DATA_WIDTH-1:0]            MEM,
  input  logic                             EX_ALU_VLD,
  output logic [$clog2(DEPTH):0]           COUNT,
  output logic [$clog2(MAX_OUTSTANDING):0] OUTSTANDING,
  output logic                             RESULT_ERR
);

  localparam int unsigned OST_W = $clog2(MAX_OUTSTANDING) + 1;

  alu_instr_t       in_instr;
  alu_instr_t       head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OST_W-1:0] ost_d;
  logic             err_d;

  assign in_instr = '{op: IN_OP, movi: IN_MOVI, reg_a: IN_REG_A,
                      reg_b: IN_REG_B, imm: IN_IMM, mem: IN_MEM};

  alu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (CLK),
    .rst_n  (RST),
    .push   (IN_VLD),
    .wdata  (in_instr),
    .pop    (ACT),
    .head_c (head),
    .count  (COUNT),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // IN_RDY depends only on occupancy, never on ALU_RDY.
  assign IN_RDY = !fifo_full;
  assign ACT    = !fifo_empty && ALU_RDY && (OUTSTANDING != OST_W'(MAX_OUTSTANDING));

  assign OP    = head.op;
  assign MOVI  = head.movi;
  assign REG_A = head.reg_a;
  assign REG_B = head.reg_b;
  assign IMM   = head.imm;
  assign MEM   = head.mem;

  // In-flight accounting; a return with nothing in flight and no same-cycle
  // issue is an error, while issue+return together is a zero-latency op.
  always_comb begin
    ost_d = OUTSTANDING;
    err_d = RESULT_ERR;
    unique case ({ACT, EX_ALU_VLD})
      2'b10: ost_d = OUTSTANDING + OST_W'(1);
      2'b01: begin
        if (OUTSTANDING == '0) begin
          err_d = 1'b1;
        end else begin
          ost_d = OUTSTANDING - OST_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUTSTANDING <= '0;
      RESULT_ERR  <= 1'b0;
    end else begin
      OUTSTANDING <= ost_d;
      RESULT_ERR  <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: accepted pushes queue the expected
// issue payload; an independent monitor pops and compares on every ACT.
module tb_alu_issue_queue;
  import sv_alu_param_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b0;
  logic                   IN_VLD = 1'b0;
  logic                   IN_RDY;
  logic [OP_WIDTH-1:0]    IN_OP = '0;
  logic [MOVI_WIDTH-1:0]  IN_MOVI = '0;
  logic [DATA_WIDTH-1:0]  IN_REG_A = '0;
  logic [DATA_WIDTH-1:0]  IN_REG_B = '0;
  logic [DATA_WIDTH-1:0]  IN_IMM = '0;
  logic [DATA_WIDTH-1:0]  IN_MEM = '0;
  logic                   ACT;
  logic                   ALU_RDY = 1'b1;
  logic [OP_WIDTH-1:0]    OP;
  logic [MOVI_WIDTH-1:0]  MOVI;
  logic [DATA_WIDTH-1:0]  REG_A;
  logic [DATA_WIDTH-1:0]  REG_B;
  logic [DATA_WIDTH-1:0]  IMM;
  logic [DATA_WIDTH-1:0]  MEM;
  logic                   EX_ALU_VLD;
  logic [$clog2(DEPTH):0] COUNT;
  logic [$clog2(MAX_OUT):0] OUTSTANDING;
  logic                   RESULT_ERR;

  logic ex_manual = 1'b0;
  logic auto_ret  = 1'b0;
  logic ret_pend  = 1'b0;
  logic act_seen  = 1'b0;
  assign EX_ALU_VLD = ex_manual | (auto_ret & ret_pend);

  alu_instr_t got;
  assign got = {OP, MOVI, REG_A, REG_B, IMM, MEM};

  alu_instr_t sb[$];
  int vecs    = 0;
  int errs    = 0;
  int act_cnt = 0;
  int a0      = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
    .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B),
    .IN_IMM(IN_IMM), .IN_MEM(IN_MEM), .ACT(ACT), .ALU_RDY(ALU_RDY),
    .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B), .IMM(IMM), .MEM(MEM),
    .EX_ALU_VLD(EX_ALU_VLD), .COUNT(COUNT), .OUTSTANDING(OUTSTANDING),
    .RESULT_ERR(RESULT_ERR)
  );

  initial forever #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One-cycle ALU model: returns each issued op on the following cycle.
  initial forever begin
    @(negedge CLK);
    act_seen = ACT;
    @(posedge CLK);
    #1 ret_pend = act_seen;
  end

  // Monitor: every issue must match the oldest expected entry.
  initial forever begin
    @(negedge CLK);
    if (RST && ACT) begin
      alu_instr_t exp;
      act_cnt++;
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL issue_order: ACT with nothing expected, got %h", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errs++;
          $display("FAIL issue_payload: got %h expected %h", got, exp);
        end
      end
    end
  end

  function automatic alu_instr_t mk(input logic [3:0] op, input logic [1:0] mv,
                                    input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] im, input logic [7:0] me);
    mk = '{op: op, movi: mv, reg_a: a, reg_b: b, imm: im, mem: me};
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vecs++;
    if (actual !== expected) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive(input alu_instr_t i);
    IN_OP = i.op; IN_MOVI = i.movi; IN_REG_A = i.reg_a;
    IN_REG_B = i.reg_b; IN_IMM = i.imm; IN_MEM = i.mem;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_one(input alu_instr_t i);
    bit ok = 1'b0;
    IN_VLD = 1'b1;
    drive(i);
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (IN_RDY) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sb.push_back(i);
    end else begin
      vecs++;
      errs++;
      $display("FAIL push_timeout: IN_RDY got 0 expected 1");
    end
    @(posedge CLK);
    #1 IN_VLD = 1'b0;
  endtask

  alu_instr_t fill [4];
  alu_instr_t third [3];

  initial begin
    fill[0] = mk(4'd1, 2'd1, 8'h11, 8'h12, 8'h13, 8'h14);
    fill[1] = mk(4'd3, 2'd2, 8'h21, 8'h22, 8'h23, 8'h24);
    fill[2] = mk(4'd4, 2'd3, 8'h31, 8'h32, 8'h33, 8'h34);
    fill[3] = mk(4'd5, 2'd0, 8'h41, 8'h42, 8'h43, 8'h44);
    third[0] = mk(4'd0, 2'd0, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    third[1] = mk(4'd1, 2'd1, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
    third[2] = mk(4'd3, 2'd2, 8'hC1, 8'hC2, 8'hC3, 8'hC4);

    // Reset and idle with ALU ready
    tick(3);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_act", 32'(ACT), 32'd0);
    check("rst_in_rdy", 32'(IN_RDY), 32'd1);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_outstanding", 32'(OUTSTANDING), 32'd0);
    check("rst_result_err", 32'(RESULT_ERR), 32'd0);
    check("rst_payload", 32'({REG_A, REG_B, IMM, MEM}), 32'd0);
    tick(1);

    // Single ADD: issue one cycle after push, returned two cycles later
    push_one(mk(OP_ADD, 2'd0, 8'h05, 8'h03, 8'h00, 8'h00));
    @(negedge CLK);
    check("add_act", 32'(ACT), 32'd1);
    check("add_reg_a", 32'(REG_A), 32'h05);
    check("add_reg_b", 32'(REG_B), 32'h03);
    tick(1);
    @(negedge CLK);
    check("add_outstanding", 32'(OUTSTANDING), 32'd1);
    check("add_count", 32'(COUNT), 32'd0);
    tick(1);
    ex_manual = 1'b1;
    tick(1);
    ex_manual = 1'b0;
    @(negedge CLK);
    check("add_retired", 32'(OUTSTANDING), 32'd0);
    check("add_no_err", 32'(RESULT_ERR), 32'd0);
    tick(1);

    // Fill to DEPTH with ALU stalled; fifth offer must be held off
    ALU_RDY = 1'b0;
    for (int i = 0; i < 4; i++) push_one(fill[i]);
    @(negedge CLK);
    check("full_count", 32'(COUNT), 32'd4);
    check("full_in_rdy", 32'(IN_RDY), 32'd0);
    check("full_act", 32'(ACT), 32'd0);
    tick(1);
    IN_VLD = 1'b1;
    drive(third[0]);
    repeat (3) begin
      @(negedge CLK);
      check("full_hold", 32'(COUNT), 32'd4);
      tick(1);
    end
    ALU_RDY  = 1'b1;
    auto_ret = 1'b1;
    a0 = act_cnt;
    push_one(third[0]);
    for (int n = 0; n < 20 && COUNT != 0; n++) tick(1);
    tick(3);
    @(negedge CLK);
    check("drain_act_pulses", 32'(act_cnt - a0), 32'd5);
    check("drain_count", 32'(COUNT), 32'd0);
    check("drain_outstanding", 32'(OUTSTANDING), 32'd0);
    check("drain_no_err", 32'(RESULT_ERR), 32'd0);
    auto_ret = 1'b0;
    tick(1);

    // In-flight limit: three queued, no returns -> only two issue
    ALU_RDY = 1'b0;
    for (int i = 0; i < 3; i++) push_one(third[i]);
    @(negedge CLK);
    check("limit_count3", 32'(COUNT), 32'd3);
    tick(1);
    a0 = act_cnt;
    ALU_RDY = 1'b1;
    tick(5);
    @(negedge CLK);
    check("limit_act_pulses", 32'(act_cnt - a0), 32'd2);
    check("limit_act_low", 32'(ACT), 32'd0);
    check("limit_count1", 32'(COUNT), 32'd1);
    check("limit_outstanding", 32'(OUTSTANDING), 32'd2);
    tick(1);
    ex_manual = 1'b1;
    @(negedge CLK);
    check("limit_act_same_cycle", 32'(ACT), 32'd0);
    tick(1);
    ex_manual = 1'b0;
    @(negedge CLK);
    check("limit_third_issue", 32'(ACT), 32'd1);
    check("limit_outstanding1", 32'(OUTSTANDING), 32'd1);
    tick(1);
    ex_manual = 1'b1;
    tick(2);
    ex_manual = 1'b0;
    @(negedge CLK);
    check("limit_retired", 32'(OUTSTANDING), 32'd0);
    check("limit_no_err", 32'(RESULT_ERR), 32'd0);
    tick(1);

    // MULT followed by ADD, ALU not ready for 9 cycles after MULT
    ALU_RDY = 1'b0;
    push_one(mk(OP_MULT, 2'd1, 8'h07, 8'h06, 8'h02, 8'h09));
    push_one(mk(OP_ADD, 2'd2, 8'h10, 8'h20, 8'h30, 8'h40));
    auto_ret = 1'b1;
    ALU_RDY  = 1'b1;
    @(negedge CLK);
    check("mult_act", 32'(ACT), 32'd1);
    check("mult_op", 32'(OP), 32'd2);
    tick(1);
    ALU_RDY = 1'b0;
    repeat (9) begin
      @(negedge CLK);
      check("mult_stall", 32'(ACT), 32'd0);
      tick(1);
    end
    ALU_RDY = 1'b1;
    @(negedge CLK);
    check("add_after_mult_act", 32'(ACT), 32'd1);
    check("add_after_mult_op", 32'(OP), 32'd0);
    tick(4);
    auto_ret = 1'b0;
    @(negedge CLK);
    check("mult_outstanding", 32'(OUTSTANDING), 32'd0);
    check("mult_no_err", 32'(RESULT_ERR), 32'd0);
    tick(1);

    // Spurious result sets a sticky error
    ex_manual = 1'b1;
    tick(1);
    ex_manual = 1'b0;
    @(negedge CLK);
    check("err_set", 32'(RESULT_ERR), 32'd1);
    check("err_outstanding", 32'(OUTSTANDING), 32'd0);
    tick(3);
    @(negedge CLK);
    check("err_sticky", 32'(RESULT_ERR), 32'd1);
    tick(1);

    // Async reset mid-burst discards queue and in-flight state
    ALU_RDY = 1'b0;
    for (int i = 0; i < 4; i++) push_one(fill[i]);
    ALU_RDY = 1'b1;
    tick(1);
    ALU_RDY = 1'b0;
    @(negedge CLK);
    check("burst_count", 32'(COUNT), 32'd3);
    check("burst_outstanding", 32'(OUTSTANDING), 32'd1);
    #2 RST = 1'b0;
    sb.delete();
    ALU_RDY = 1'b1;
    #1;
    check("async_rst_count", 32'(COUNT), 32'd0);
    check("async_rst_outstanding", 32'(OUTSTANDING), 32'd0);
    check("async_rst_err", 32'(RESULT_ERR), 32'd0);
    check("async_rst_act", 32'(ACT), 32'd0);
    check("async_rst_in_rdy", 32'(IN_RDY), 32'd1);
    tick(2);
    RST = 1'b1;
    ex_manual = 1'b1;
    tick(1);
    ex_manual = 1'b0;
    @(negedge CLK);
    check("post_rst_result_err", 32'(RESULT_ERR), 32'd1);
    check("post_rst_outstanding", 32'(OUTSTANDING), 32'd0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
